// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
//   Shared definitions for the instruction-memory loader.
//   The loader FSM state enum lives here.
//   The default instruction-memory geometry also lives here, so the memory
//   and the loader agree on it.
package imem_loader_pkg;

    localparam int IMEM_ADDR_W = 8;   // word-address width, depth 2^IMEM_ADDR_W
    localparam int IMEM_DATA_W = 32;  // instruction word width

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_DONE,
        ST_FAIL
    } state_t;

endpackage

// File: rtl/imem_loader.sv
// imem_loader
//   Streams instruction words into the instruction memory while holding the
//   CPU in reset. Words are written to consecutive addresses starting at 0,
//   and a mod-2^DATA_WIDTH checksum is accumulated as they arrive. The CPU is
//   released only when the final checksum equals the value latched at start.
//
// Ports
//   i_clk           system clock, rising edge
//   i_rst_n         synchronous active-low reset
//   i_start         single-cycle load request
//   i_word_count    words to load (ADDR_WIDTH+1 bits), sampled on accepted start
//   i_exp_checksum  expected word sum, sampled on accepted start
//   i_s_valid       input stream valid
//   i_s_data        input stream word
//   o_s_ready       loader accepts a word this cycle
//   o_imem_we       instruction-memory write strobe
//   o_imem_addr     write word address
//   o_imem_wdata    write data
//   o_cpu_hold      1 = CPU held in reset
//   o_busy          load or check in progress
//   o_done          load verified, CPU released
//   o_error         bad word count or checksum mismatch
//   o_checksum      running sum of accepted words
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = IMEM_ADDR_W,
    parameter int DATA_WIDTH = IMEM_DATA_W
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH:0]   i_word_count,
    input  logic [DATA_WIDTH-1:0] i_exp_checksum,
    input  logic                  i_s_valid,
    input  logic [DATA_WIDTH-1:0] i_s_data,
    output logic                  o_s_ready,
    output logic                  o_imem_we,
    output logic [ADDR_WIDTH-1:0] o_imem_addr,
    output logic [DATA_WIDTH-1:0] o_imem_wdata,
    output logic                  o_cpu_hold,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic [DATA_WIDTH-1:0] o_checksum
);

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH:0]   r_count;
    logic [ADDR_WIDTH:0]   r_index;
    logic [DATA_WIDTH-1:0] r_exp;
    logic [DATA_WIDTH-1:0] r_checksum;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic w_can_start;
    logic w_start_ok;
    logic w_start_bad;
    logic w_accept;
    logic w_hs;
    logic w_last;

    // Starts are honoured only from the resting states; LOAD/CHECK ignore them.
    assign w_can_start = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_FAIL);
    assign w_start_ok  = i_start && (i_word_count != '0) && (i_word_count <= DEPTH);
    assign w_start_bad = i_start && (i_word_count > DEPTH);
    assign w_accept    = w_can_start && w_start_ok;
    assign w_hs        = (r_state == ST_LOAD) && i_s_valid;
    // Index is one bit wider than the address so a full-depth count is reachable.
    assign w_last      = (r_index + ONE) == r_count;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (w_start_bad)     w_state_nxt = ST_FAIL;
                else if (w_start_ok) w_state_nxt = ST_LOAD;
            end
            ST_LOAD:  if (w_hs && w_last) w_state_nxt = ST_CHECK;
            // The last word's sum is already in r_checksum here.
            ST_CHECK: w_state_nxt = (r_checksum == r_exp) ? ST_DONE : ST_FAIL;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_index    <= '0;
            r_exp      <= '0;
            r_checksum <= '0;
            r_we       <= 1'b0;   // drops any in-flight write
            r_addr     <= '0;
            r_wdata    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_we    <= w_hs;
            if (w_accept) begin
                r_count    <= i_word_count;
                r_exp      <= i_exp_checksum;
                r_index    <= '0;
                r_checksum <= '0;
            end
            if (w_hs) begin
                r_addr     <= r_index[ADDR_WIDTH-1:0];
                r_wdata    <= i_s_data;
                r_checksum <= r_checksum + i_s_data;
                r_index    <= r_index + ONE;
            end
        end
    end

    // Status outputs are pure decodes of the state register, so they carry no
    // combinational path from inputs.
    assign o_s_ready    = (r_state == ST_LOAD);
    assign o_busy       = (r_state == ST_LOAD) || (r_state == ST_CHECK);
    assign o_done       = (r_state == ST_DONE);
    assign o_error      = (r_state == ST_FAIL);
    assign o_cpu_hold   = (r_state != ST_DONE);
    assign o_imem_we    = r_we;
    assign o_imem_addr  = r_addr;
    assign o_imem_wdata = r_wdata;
    assign o_checksum   = r_checksum;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int AW = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW:0]   word_count;
    logic [DW-1:0] exp_cs;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_wdata;
    logic          cpu_hold;
    logic          busy;
    logic          done;
    logic          error;
    logic [DW-1:0] checksum;

    int checks   = 0;
    int failures = 0;
    int we_cnt   = 0;

    logic [DW-1:0] wbuf [0:256];

    imem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_start        (start),
        .i_word_count   (word_count),
        .i_exp_checksum (exp_cs),
        .i_s_valid      (s_valid),
        .i_s_data       (s_data),
        .o_s_ready      (s_ready),
        .o_imem_we      (imem_we),
        .o_imem_addr    (imem_addr),
        .o_imem_wdata   (imem_wdata),
        .o_cpu_hold     (cpu_hold),
        .o_busy         (busy),
        .o_done         (done),
        .o_error        (error),
        .o_checksum     (checksum)
    );

    always #5 clk = ~clk;

    // Count write strobes seen at the sampling edge.
    always @(negedge clk) if (imem_we === 1'b1) we_cnt++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Reference behaviour of one session: words wbuf[0..cnt-1] land at
    // addresses 0..cnt-1 one cycle after each handshake; the outcome is
    // decided by the plain sum of the words against the expected value.
    // Called with the bench sitting on a negedge; returns on a negedge.
    // mode: 0 back-to-back, 1 three idle cycles before word 2, 2 random gaps.
    task automatic run_load(input string nm, input int cnt, input logic [DW-1:0] exp, input int mode);
        logic [DW-1:0] sum;
        int            gaps;
        bit            ok;
        sum = '0;
        for (int i = 0; i < cnt; i++) sum += wbuf[i];
        ok = (sum == exp);

        start = 1'b1; word_count = cnt[AW:0]; exp_cs = exp;
        @(negedge clk);
        start = 1'b0;
        // LOAD entered: ready, busy, CPU held, checksum cleared.
        chk({nm, ".enter"}, {busy, s_ready, cpu_hold, done, error, checksum},
            {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0});

        for (int i = 0; i < cnt; i++) begin
            gaps = (mode == 1 && i == 2) ? 3 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
            for (int g = 0; g < gaps; g++) begin
                s_valid = 1'b0; s_data = $urandom;
                @(negedge clk);
                chk({nm, ".gap_we"}, imem_we, 1'b0);
            end
            s_valid = 1'b1; s_data = wbuf[i];
            // An unrelated start during LOAD must not disturb the session.
            if (mode == 2 && i == 1) begin start = 1'b1; word_count = 9'd3; end
            @(negedge clk);
            start = 1'b0;
            chk({nm, ".write"}, {imem_we, imem_addr, imem_wdata}, {1'b1, i[AW-1:0], wbuf[i]});
        end
        s_valid = 1'b0; s_data = $urandom;
        // Cycle after the last handshake: CHECK.
        chk({nm, ".check"}, {busy, s_ready, done, error, cpu_hold}, {1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
        @(negedge clk);
        chk({nm, ".final"}, {busy, done, error, cpu_hold, imem_we, checksum},
            {1'b0, ok, !ok, !ok, 1'b0, sum});
    endtask

    typedef struct {
        string         nm;
        int            cnt;
        logic [DW-1:0] base;
        logic [DW-1:0] step;
        logic [DW-1:0] delta;   // 0: expected checksum matches the word sum
        int            mode;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [DW-1:0] s;
        int            n;
        int            w0;

        vecs[0] = '{"basic",    4,   32'h1,        32'h1,  32'h0, 0};
        vecs[1] = '{"stall",    4,   32'h1,        32'h1,  32'h0, 1};
        vecs[2] = '{"mismatch", 2,   32'h10,       32'h10, 32'h1, 0};
        vecs[3] = '{"wrapsum",  2,   32'hFFFFFFFF, 32'h3,  32'h0, 0};
        vecs[4] = '{"full",     256, 32'h100,      32'h7,  32'h0, 0};
        vecs[5] = '{"single",   1,   32'hDEADBEEF, 32'h0,  32'h0, 0};

        rst_n = 1'b0; start = 1'b0; word_count = '0; exp_cs = '0;
        s_valid = 1'b0; s_data = '0;
        repeat (2) @(negedge clk);
        chk("reset", {s_ready, imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, error},
            {1'b0, 1'b0, 8'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0});
        chk("reset_cs", checksum, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero-length start is ignored.
        start = 1'b1; word_count = 9'd0; exp_cs = 32'h0;
        @(negedge clk);
        start = 1'b0;
        chk("count0", {busy, s_ready, done, error, cpu_hold}, {1'b0, 1'b0, 1'b0, 1'b0, 1'b1});

        // Oversized start fails immediately with no writes.
        w0 = we_cnt;
        start = 1'b1; word_count = 9'd257;
        @(negedge clk);
        start = 1'b0;
        chk("count257", {busy, s_ready, done, error, cpu_hold}, {1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
        repeat (2) @(negedge clk);
        chk("count257_nowr", we_cnt - w0, 0);

        // Table vectors; each one after the first reloads from DONE or FAIL.
        foreach (vecs[v]) begin
            s = '0;
            for (int i = 0; i < vecs[v].cnt; i++) begin
                wbuf[i] = vecs[v].base + vecs[v].step * i;
                s += wbuf[i];
            end
            run_load(vecs[v].nm, vecs[v].cnt, s + vecs[v].delta, vecs[v].mode);
        end
        // Explicit expectations for the named cases, independent of the model.
        chk("full_lastaddr", {8'hFF, wbuf[255]}, {8'hFF, 32'h100 + 32'd7 * 32'd255});

        // Reset after the second handshake of a five-word load.
        for (int i = 0; i < 5; i++) wbuf[i] = $urandom;
        start = 1'b1; word_count = 9'd5; exp_cs = 32'h0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_valid = 1'b1; s_data = wbuf[i];
            @(negedge clk);
        end
        chk("rst_mid_inflight", imem_we, 1'b1);
        s_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid", {s_ready, imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, error, checksum},
            {1'b0, 1'b0, 8'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
        rst_n = 1'b1;
        @(negedge clk);
        s = '0;
        for (int i = 0; i < 5; i++) s += wbuf[i];
        run_load("after_rst", 5, s, 0);
        chk("after_rst_done", {done, cpu_hold}, {1'b1, 1'b0});

        // Randomized sessions with random gaps and random match/mismatch.
        for (int r = 0; r < 20; r++) begin
            n = $urandom_range(1, 40);
            s = '0;
            for (int i = 0; i < n; i++) begin
                wbuf[i] = $urandom;
                s += wbuf[i];
            end
            if ($urandom_range(0, 2) == 0) s = s + $urandom_range(1, 1000);
            run_load($sformatf("rand%0d", r), n, s, 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that writes a stream of 32-bit instruction words into the single-cycle processor's instruction memory. It holds the processor in reset while loading, then releases it. It accepts words over a valid/ready stream, assigns consecutive word addresses from 0, and keeps a running 32-bit checksum. It releases the processor only when that checksum matches the expected value latched at start.

## Interface
Parameters:
- ADDR_WIDTH, 8, instruction-memory word-address width (depth 2^ADDR_WIDTH words)
- DATA_WIDTH, 32, instruction word width

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  synchronous, active-low reset
- start  in  1  single-cycle request to begin a load session
- word_count  in  ADDR_WIDTH+1  number of words to load; sampled when start is accepted
- exp_checksum  in  DATA_WIDTH  expected mod-2^32 sum of all words; sampled when start is accepted
- s_valid  in  1  input word valid
- s_data  in  DATA_WIDTH  input word
- s_ready  out  1  loader accepts a word this cycle
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  ADDR_WIDTH  word address for the write
- imem_wdata  out  DATA_WIDTH  write data
- cpu_hold  out  1  high = processor held in reset
- busy  out  1  high in LOAD and CHECK
- done  out  1  high in DONE
- error  out  1  high in FAIL
- checksum  out  DATA_WIDTH  running sum of accepted words

## Operation
- States: IDLE, LOAD, CHECK, DONE, FAIL.
- IDLE:
  - start with word_count = 0 is ignored; the block stays in IDLE.
  - start with word_count > 2^ADDR_WIDTH goes to FAIL.
  - Otherwise, start latches word_count and exp_checksum, clears the index and checksum, and goes to LOAD.
- LOAD:
  - s_ready = 1.
  - Each handshake (s_valid & s_ready) registers the write: imem_addr = index, imem_wdata = s_data, imem_we = 1 on the next cycle.
  - Each handshake also adds s_data to checksum mod 2^32 and increments the index.
  - The handshake that brings the accepted count to word_count moves the FSM to CHECK.
  - s_valid low stalls; no timeout.
- CHECK (one cycle):
  - s_ready = 0.
  - The final write is visible this cycle.
  - checksum == exp_checksum goes to DONE; otherwise goes to FAIL.
- DONE: cpu_hold = 0, done = 1.
- FAIL: cpu_hold = 1, error = 1.
- From DONE or FAIL, start follows the same acceptance rules as in IDLE and starts a reload; cpu_hold rises the cycle after start.
- start in LOAD or CHECK is ignored.
- Words arriving while s_ready = 0 are not consumed.
- Memory content is never cleared by this block; a partial load leaves the written words in place.
- Address arithmetic:
  - The index is ADDR_WIDTH+1 bits; imem_addr is the low ADDR_WIDTH bits.
  - A full-depth load (word_count = 2^ADDR_WIDTH) writes addresses 0..2^ADDR_WIDTH-1 with no wrap.

## Timing
- Reset values: s_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, cpu_hold 1, busy 0, done 0, error 0, checksum 0; state IDLE.
- Reset mid-load: everything returns to the reset values next cycle. The in-flight registered write is dropped: imem_we is 0 after the reset edge.
- All outputs are registered; s_ready decodes directly from the state register.
- start accepted at cycle T gives LOAD and s_ready = 1 at T+1.
- Throughput: one word per cycle.
- Write latency: one cycle from handshake to imem_we.
- checksum updates one cycle after each handshake.
- Last handshake at cycle N:
  - imem_we for the last word at N+1 (CHECK).
  - done/error and cpu_hold change at N+2.
  - busy falls at N+2.
- imem_we is a single-cycle pulse per word and is never asserted outside the cycle following a handshake.

## Structure
- Shared package imem_loader_pkg holds:
  - the state enum (IDLE, LOAD, CHECK, DONE, FAIL);
  - default ADDR_WIDTH and DATA_WIDTH constants, also used by the instruction memory.
- Single module. No sub-module is warranted: the FSM, index counter, checksum adder and write register are each a few lines.

## Test plan
- Basic load: start, word_count = 4, exp_checksum = 0x0000000A, back-to-back words 1,2,3,4 -> writes to addr 0..3 on consecutive cycles; DONE and cpu_hold = 0 two cycles after the 4th handshake; checksum = 0xA.
- Stalled stream: same load with s_valid low for 3 cycles between words 2 and 3 -> no imem_we during the gap; identical final state.
- Checksum mismatch: words 0x10, 0x20 with exp_checksum 0x31 -> error = 1, cpu_hold stays 1, done = 0.
- Bounds:
  - word_count = 0 -> stays IDLE.
  - word_count = 257 (ADDR_WIDTH = 8) -> FAIL next cycle, no writes.
  - word_count = 256 -> last write at addr 0xFF.
  - Wrapping sum 0xFFFFFFFF + 0x2 -> checksum 0x1.
- Reset mid-load: Reset low after the 2nd handshake of a 5-word load -> next cycle all outputs at reset values with imem_we = 0; a subsequent full load succeeds.
- Reload from DONE: start after DONE with new words -> cpu_hold = 1 the cycle after start; new checksum starts from 0.
